mem_arbiter: RTL and testbench

Two-port round-robin arbiter sharing the single-port 256-word data memory (combinational read, write on rising clock edge) between two requesters. Typical pairing: the processor data port on port 0 and the test loader or checker on port 1. A lock input lets a requester hold the memory across a read-modify-write sequence, such as a heapsort swap. Lock duration is capped so the other port cannot starve.

---
 rtl/mem_arb_pkg.sv | 5 +
 rtl/mem_arbiter.sv | 63 ++++++
 tb/tb_mem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
  localparam int NPORTS = 2;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter with capped locking for a single-port memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_a,
  input  logic [31:0] m1_a,
  input  logic [31:0] m0_wd,
  input  logic [31:0] m1_wd,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rd,
  output logic [31:0] m1_rd,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  localparam int CW = $clog2(MAX_LOCK + 1);
  owner_t owner, owner_n;
  logic prio, prio_n;
  logic [CW-1:0] lock_cnt, cnt_n;
  logic [NPORTS-1:0] gnt;
  logic own0, own1, lk, keep;
  always_comb begin
    own0 = owner == OWN_M0 && m0_req;
    own1 = owner == OWN_M1 && m1_req;
    gnt[0] = !reset && !own1 && (own0 || (m0_req && (!m1_req || !prio)));
    gnt[1] = !reset && !own0 && (own1 || (m1_req && (!m0_req || prio)));
    lk = gnt[0] ? m0_lock : m1_lock;
    keep = |gnt && lk && (int'(lock_cnt) + 1 < MAX_LOCK);
    prio_n = |gnt ? gnt[0] : prio;
    owner_n = keep ? (gnt[0] ? OWN_M0 : OWN_M1) : OWN_NONE;
    cnt_n = keep ? lock_cnt + 1'b1 : '0;
    m0_gnt = gnt[0];
    m1_gnt = gnt[1];
    mem_we = gnt[0] ? m0_we : gnt[1] ? m1_we : 1'b0;
    mem_a = gnt[0] ? m0_a : gnt[1] ? m1_a : '0;
    mem_wd = gnt[0] ? m0_wd : gnt[1] ? m1_wd : '0;
    m0_rd = gnt[0] ? mem_rd : '0;
    m1_rd = gnt[1] ? mem_rd : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
      owner <= OWN_NONE;
      lock_cnt <= '0;
    end else begin
      prio <= prio_n;
      owner <= owner_n;
      lock_cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural 256-word memory beside it
module tb_mem_arbiter;
  typedef struct packed {
    logic g0, g1, we;
    logic [31:0] a, wd, rd0, rd1;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 0, m1_req = 0, m0_lock = 0, m1_lock = 0, m0_we = 0, m1_we = 0;
  logic [31:0] m0_a = 0, m1_a = 0, m0_wd = 0, m1_wd = 0;
  logic m0_gnt, m1_gnt, mem_we;
  logic [31:0] m0_rd, m1_rd, mem_a, mem_wd, mem_rd;
  logic [31:0] mem [256];
  exp_t q[$];
  string nq[$];
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  mem_arbiter #(.MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_a(m0_a), .m1_a(m1_a),
    .m0_wd(m0_wd), .m1_wd(m1_wd), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rd(m0_rd), .m1_rd(m1_rd), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;
  task automatic cyc(input string nm, input logic rst,
                     input logic r0, l0, w0, input logic [31:0] a0, d0,
                     input logic r1, l1, w1, input logic [31:0] a1, d1,
                     input logic e0, e1, input logic [31:0] erd);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    m0_req = r0; m0_lock = l0; m0_we = w0; m0_a = a0; m0_wd = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_a = a1; m1_wd = d1;
    e.g0 = e0;
    e.g1 = e1;
    e.we = e0 ? w0 : e1 ? w1 : 1'b0;
    e.a = e0 ? a0 : e1 ? a1 : 32'h0;
    e.wd = e0 ? d0 : e1 ? d1 : 32'h0;
    e.rd0 = e0 ? erd : 32'h0;
    e.rd1 = e1 ? erd : 32'h0;
    q.push_back(e);
    nq.push_back(nm);
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, act;
      string n;
      e = q.pop_front();
      n = nq.pop_front();
      act = {m0_gnt, m1_gnt, mem_we, mem_a, mem_wd, m0_rd, m1_rd};
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got g0=%b g1=%b we=%b a=%h wd=%h rd0=%h rd1=%h, want g0=%b g1=%b we=%b a=%h wd=%h rd0=%h rd1=%h",
                 n, act.g0, act.g1, act.we, act.a, act.wd, act.rd0, act.rd1,
                 e.g0, e.g1, e.we, e.a, e.wd, e.rd0, e.rd1);
      end
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hCAFE0000 | i;
    cyc("rst0", 1, 1,0,1, 32'h10, 32'h5, 1,0,0, 32'h4, 0, 0,0, 0);
    cyc("rst1", 1, 1,1,1, 32'h10, 32'h5, 1,1,1, 32'h4, 32'h6, 0,0, 0);
    cyc("rd_m0", 0, 1,0,0, 32'h10, 0, 0,0,0, 0, 0, 1,0, 32'hCAFE0004);
    cyc("rst_a", 1, 0,0,0, 0, 0, 0,0,0, 0, 0, 0,0, 0);
    cyc("alt0", 0, 1,0,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("alt1", 0, 1,0,0, 32'h0, 0, 1,0,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    cyc("alt2", 0, 1,0,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("alt3", 0, 1,0,0, 32'h0, 0, 1,0,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    cyc("wr_c0", 0, 1,0,1, 32'h20, 32'h22222222, 1,0,1, 32'h20, 32'h11111111, 1,0, 32'hCAFE0008);
    cyc("wr_c1", 0, 0,0,0, 32'h20, 0, 1,0,1, 32'h20, 32'h11111111, 0,1, 32'h22222222);
    cyc("wr_rd", 0, 1,0,0, 32'h20, 0, 0,0,0, 0, 0, 1,0, 32'h11111111);
    #1;
    compared++;
    if (mem[8] !== 32'h11111111) begin
      mismatched++;
      $display("FAIL word8: got %h want %h", mem[8], 32'h11111111);
    end
    cyc("rst_b", 1, 0,0,0, 0, 0, 0,0,0, 0, 0, 0,0, 0);
    cyc("cap0", 0, 1,1,0, 32'h0, 0, 0,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    for (int i = 1; i < 4; i++)
      cyc($sformatf("cap%0d", i), 0, 1,1,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("cap4", 0, 1,1,0, 32'h0, 0, 1,0,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    for (int i = 5; i < 8; i++)
      cyc($sformatf("cap%0d", i), 0, 1,1,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("idle", 0, 0,1,1, 32'h8, 32'h9, 0,1,1, 32'hC, 32'h9, 0,0, 0);
    cyc("rst_c", 1, 0,0,0, 0, 0, 0,0,0, 0, 0, 0,0, 0);
    cyc("rel0", 0, 1,1,0, 32'h0, 0, 0,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("rel1", 0, 1,1,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("rel2", 0, 0,1,0, 32'h0, 0, 1,0,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    cyc("rel3", 0, 1,0,0, 32'h0, 0, 1,0,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("ml0", 0, 0,0,0, 32'h0, 0, 1,1,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    cyc("ml1", 0, 1,0,0, 32'h0, 0, 1,1,0, 32'h4, 0, 0,1, 32'hCAFE0001);
    cyc("ml_rst", 1, 1,0,1, 32'h0, 32'h7, 1,1,1, 32'h4, 32'h7, 0,0, 0);
    cyc("ml3", 0, 1,0,0, 32'h0, 0, 1,1,0, 32'h4, 0, 1,0, 32'hCAFE0000);
    cyc("end", 0, 0,0,0, 0, 0, 0,0,0, 0, 0, 0,0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
